dummy_accelerator_result_fifo: RTL and testbench
================================================

DUMMY_ACCELERATOR_RESULT_FIFO -- requirements
Module: dummy_accelerator_result_fifo

Interface
REQ-001: The block SHALL have parameter WIDTH, default 32, giving the result data width in bits.
REQ-002: The block SHALL have parameter DEPTH, default 4, giving the number of FIFO entries; it is a power of two and at least 2.
REQ-003: The block SHALL have parameter tag_type_t, default logic, giving the tag carried alongside each result.
REQ-004: The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005: The block SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-006: The block SHALL have port flush_i, input, 1 bit: synchronous clear of all stored entries.
REQ-007: The block SHALL have port valid_i, input, 1 bit: upstream accelerator result valid.
REQ-008: The block SHALL have port ready_o, output, 1 bit: FIFO can accept an entry; drives the accelerator's ready_i.
REQ-009: The block SHALL have port result_i, input, WIDTH bits: upstream result.
REQ-010: The block SHALL have port tag_i, input, tag_type_t: upstream tag.
REQ-011: The block SHALL have port valid_o, output, 1 bit: head entry valid towards the core write-back.
REQ-012: The block SHALL have port ready_i, input, 1 bit: downstream accepts the head entry.
REQ-013: The block SHALL have port result_o, output, WIDTH bits: head entry result.
REQ-014: The block SHALL have port tag_o, output, tag_type_t: head entry tag.
REQ-015: The block SHALL have port count_o, output, $clog2(DEPTH+1) bits: current occupancy.

Function
REQ-016: A push SHALL occur when valid_i && ready_o; a pop SHALL occur when valid_o && ready_i.
REQ-017: ready_o SHALL equal (count != DEPTH) and SHALL be independent of ready_i, so there is no push-through when full.
REQ-018: valid_o SHALL equal (count != 0), with no combinational bypass; an entry pushed in cycle N is first visible at the output in cycle N+1.
REQ-019: result_o and tag_o SHALL present the entry at the read pointer; their value is don't-care while valid_o=0.
REQ-020: Entries SHALL leave in push order (FIFO) with no reordering or duplication.
REQ-021: The write and read pointers SHALL each be log2(DEPTH) bits wide and wrap from DEPTH-1 to 0.
REQ-022: A simultaneous push and pop with 0<count<DEPTH SHALL leave count unchanged and advance both pointers.
REQ-023: A pop SHALL decrement count; a push SHALL increment count.
REQ-024: valid_i while full SHALL be held off by ready_o=0, and the FIFO SHALL not overwrite storage.
REQ-025: ready_i while empty SHALL have no effect.
REQ-026: When flush_i=1, on the next edge count and both pointers SHALL become 0, overriding any push or pop in that cycle.
REQ-027: After a flush, valid_o SHALL be 0 and ready_o SHALL be 1.
REQ-028: Storage contents SHALL not be cleared by flush.
REQ-029: valid_i/result_i/tag_i SHALL be sampled only on a push; held or changing values without a push SHALL have no effect.

Reset
REQ-030: While rst_ni=0, count_o, the pointers and the storage SHALL be asynchronously set to 0, giving outputs valid_o=0, ready_o=1, result_o=0, tag_o=0, count_o=0.
REQ-031: Reset asserted mid-operation SHALL discard all entries immediately; the first push after deassertion SHALL be the first entry popped.

Structure
REQ-032: Default WIDTH and DEPTH constants SHALL reside in shared package dummy_accelerator_pkg, alongside the accelerator configuration/tag typedefs.
REQ-033: The block SHALL be a single module with no sub-modules: storage array, pointer registers and a count register.

Verification
REQ-034: Reset then single push (result=0x0000_00A5, tag=1) with ready_i=0 SHALL give valid_o=1 one cycle later, result_o=0x0000_00A5, tag_o=1, count_o=1.
REQ-035: Four pushes 0x1,0x2,0x3,0x4 with ready_i=0 SHALL give count_o=4 and ready_o=0; a fifth valid_i SHALL be held off; draining SHALL output 0x1..0x4 in order.
REQ-036: Continuous push and pop at count=2 for 10 cycles SHALL hold count_o=2, wrap the pointers at least twice, and keep output order matching input order.
REQ-037: flush_i asserted with count=3 concurrent with a push and a pop SHALL give count_o=0, valid_o=0 and ready_o=1 next cycle.
REQ-038: rst_ni asserted asynchronously mid-cycle with count=2 SHALL give valid_o=0 and count_o=0 without waiting for a clock edge.
REQ-039: ready_i=1 with an empty FIFO for 5 cycles SHALL keep count_o=0 and leave the pointers unchanged.

Source files
------------

// File: rtl/dummy_accelerator_pkg.sv
// Shared accelerator definitions: result FIFO defaults plus the configuration
// and tag types used between the accelerator and the core write-back path.
package dummy_accelerator_pkg;

  localparam int unsigned ResultWidth     = 32;
  localparam int unsigned ResultFifoDepth = 4;
  localparam int unsigned TagWidth        = 4;

  typedef logic [TagWidth-1:0] acc_tag_t;

  typedef enum logic [1:0] {
    ACC_OP_NOP  = 2'd0,
    ACC_OP_ADD  = 2'd1,
    ACC_OP_MUL  = 2'd2,
    ACC_OP_MAC  = 2'd3
  } acc_op_e;

  typedef struct packed {
    logic    enable;
    acc_op_e op;
  } acc_cfg_t;

endpackage

// File: rtl/dummy_accelerator_result_fifo.sv
// Result FIFO between the accelerator and core write-back: registered output,
// no bypass, no push-through when full, synchronous flush.
module dummy_accelerator_result_fifo
  import dummy_accelerator_pkg::*;
#(
  parameter int unsigned WIDTH = ResultWidth,
  parameter int unsigned DEPTH = ResultFifoDepth,
  parameter type tag_type_t = logic
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [WIDTH-1:0]           result_i,
  input  tag_type_t                  tag_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [WIDTH-1:0]           result_o,
  output tag_type_t                  tag_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] result_q [DEPTH];
  tag_type_t        tag_q    [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q,  count_d;
  logic             push, pop;

  assign ready_o = (count_q != CntW'(DEPTH));
  assign valid_o = (count_q != '0);
  assign push    = valid_i && ready_o;
  assign pop     = valid_o && ready_i;

  assign result_o = result_q[rd_ptr_q];
  assign tag_o    = tag_q[rd_ptr_q];
  assign count_o  = count_q;

  // DEPTH is a power of two, so pointers wrap naturally on overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is reset on purpose so result_o/tag_o read 0 out of reset;
  // a flush only moves pointers and leaves the array contents alone.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        result_q[i] <= '0;
        tag_q[i]    <= '0;
      end
    end else if (push && !flush_i) begin
      result_q[wr_ptr_q] <= result_i;
      tag_q[wr_ptr_q]    <= tag_i;
    end
  end

endmodule

// File: tb/tb_dummy_accelerator_result_fifo.sv
// Self-checking bench: vector table plus hand sequences, with a queue-based
// reference model predicting occupancy and the popped result/tag stream.
module tb_dummy_accelerator_result_fifo;
  import dummy_accelerator_pkg::*;

  localparam int unsigned W = 32;
  localparam int unsigned D = 4;

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic           flush_i, valid_i, ready_i;
  logic           ready_o, valid_o;
  logic [W-1:0]   result_i, result_o;
  acc_tag_t       tag_i, tag_o;
  logic [2:0]     count_o;

  dummy_accelerator_result_fifo #(
    .WIDTH      (W),
    .DEPTH      (D),
    .tag_type_t (acc_tag_t)
  ) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .flush_i  (flush_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .result_i (result_i),
    .tag_i    (tag_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .result_o (result_o),
    .tag_o    (tag_o),
    .count_o  (count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [W-1:0] result;
    acc_tag_t     tag;
  } entry_t;

  typedef struct {
    logic         valid;
    logic         ready;
    logic         flush;
    logic [W-1:0] result;
    acc_tag_t     tag;
    int           exp_count;
    logic         chk_head;
    logic [W-1:0] exp_result;
    acc_tag_t     exp_tag;
  } vec_t;

  entry_t sb[$];
  vec_t   vec[13];
  int     checks   = 0;
  int     failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model decides push/pop from its own occupancy.
  task automatic drive(input logic v, input logic r, input logic f,
                       input logic [W-1:0] res, input acc_tag_t tg);
    entry_t e;
    bit     m_push, m_pop;
    @(negedge clk_i);
    valid_i  = v;
    ready_i  = r;
    flush_i  = f;
    result_i = res;
    tag_i    = tg;
    #1;
    m_pop  = r && (sb.size() != 0);
    m_push = v && (sb.size() != int'(D));
    if (f) begin
      sb.delete();
    end else begin
      if (m_pop) begin
        e = sb.pop_front();
        check("pop_result", 64'(result_o), 64'(e.result));
        check("pop_tag", 64'(tag_o), 64'(e.tag));
      end
      if (m_push) sb.push_back('{res, tg});
    end
    @(posedge clk_i);
    #1;
    check("count", 64'(count_o), 64'(sb.size()));
    check("valid_o", 64'(valid_o), 64'(sb.size() != 0));
    check("ready_o", 64'(ready_o), 64'(sb.size() != int'(D)));
  endtask

  initial begin
    // Single push, then the full/overflow/drain sequence with an idle row
    // whose changing result_i must not be captured.
    vec[0]  = '{1'b1, 1'b0, 1'b0, 32'h0000_00A5, 4'h1, 1, 1'b1, 32'h0000_00A5, 4'h1};
    vec[1]  = '{1'b0, 1'b1, 1'b0, 32'h0,         4'h0, 0, 1'b0, 32'h0, 4'h0};
    vec[2]  = '{1'b1, 1'b0, 1'b0, 32'h1,         4'h1, 1, 1'b1, 32'h1, 4'h1};
    vec[3]  = '{1'b1, 1'b0, 1'b0, 32'h2,         4'h2, 2, 1'b1, 32'h1, 4'h1};
    vec[4]  = '{1'b1, 1'b0, 1'b0, 32'h3,         4'h3, 3, 1'b0, 32'h0, 4'h0};
    vec[5]  = '{1'b1, 1'b0, 1'b0, 32'h4,         4'h4, 4, 1'b1, 32'h1, 4'h1};
    vec[6]  = '{1'b1, 1'b0, 1'b0, 32'h5,         4'h5, 4, 1'b1, 32'h1, 4'h1};
    vec[7]  = '{1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 4'hF, 4, 1'b1, 32'h1, 4'h1};
    vec[8]  = '{1'b0, 1'b1, 1'b0, 32'h0,         4'h0, 3, 1'b1, 32'h2, 4'h2};
    vec[9]  = '{1'b0, 1'b1, 1'b0, 32'h0,         4'h0, 2, 1'b1, 32'h3, 4'h3};
    vec[10] = '{1'b0, 1'b1, 1'b0, 32'h0,         4'h0, 1, 1'b1, 32'h4, 4'h4};
    vec[11] = '{1'b0, 1'b1, 1'b0, 32'h0,         4'h0, 0, 1'b0, 32'h0, 4'h0};
    vec[12] = '{1'b0, 1'b1, 1'b0, 32'h0,         4'h0, 0, 1'b0, 32'h0, 4'h0};

    rst_ni   = 1'b0;
    flush_i  = 1'b0;
    valid_i  = 1'b0;
    ready_i  = 1'b0;
    result_i = '0;
    tag_i    = '0;
    #12;
    check("rst_valid_o", 64'(valid_o), 64'd0);
    check("rst_ready_o", 64'(ready_o), 64'd1);
    check("rst_result_o", 64'(result_o), 64'd0);
    check("rst_tag_o", 64'(tag_o), 64'd0);
    check("rst_count_o", 64'(count_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < 13; i++) begin
      drive(vec[i].valid, vec[i].ready, vec[i].flush, vec[i].result, vec[i].tag);
      check($sformatf("tbl_count[%0d]", i), 64'(count_o), 64'(vec[i].exp_count));
      if (vec[i].chk_head) begin
        check($sformatf("tbl_head_result[%0d]", i), 64'(result_o), 64'(vec[i].exp_result));
        check($sformatf("tbl_head_tag[%0d]", i), 64'(tag_o), 64'(vec[i].exp_tag));
      end
    end

    // Steady push+pop at occupancy 2; ten pushes wrap the pointers twice.
    drive(1'b1, 1'b0, 1'b0, 32'h100, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h101, 4'h1);
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h200 + 32'(k), acc_tag_t'(k));
      check("stream_count", 64'(count_o), 64'd2);
    end
    drive(1'b0, 1'b1, 1'b0, 32'h0, 4'h0);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 4'h0);

    // Flush at occupancy 3 overrides a concurrent push and pop.
    drive(1'b1, 1'b0, 1'b0, 32'h300, 4'h3);
    drive(1'b1, 1'b0, 1'b0, 32'h301, 4'h4);
    drive(1'b1, 1'b0, 1'b0, 32'h302, 4'h5);
    check("pre_flush_count", 64'(count_o), 64'd3);
    drive(1'b1, 1'b1, 1'b1, 32'h3FF, 4'hF);
    check("flush_count", 64'(count_o), 64'd0);
    check("flush_valid_o", 64'(valid_o), 64'd0);
    check("flush_ready_o", 64'(ready_o), 64'd1);
    drive(1'b1, 1'b0, 1'b0, 32'h310, 4'h6);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 4'h0);

    // Asynchronous reset in the middle of a cycle with two entries held.
    drive(1'b1, 1'b0, 1'b0, 32'h400, 4'h7);
    drive(1'b1, 1'b0, 1'b0, 32'h401, 4'h8);
    valid_i = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    check("arst_valid_o", 64'(valid_o), 64'd0);
    check("arst_count_o", 64'(count_o), 64'd0);
    check("arst_ready_o", 64'(ready_o), 64'd1);
    sb.delete();
    @(negedge clk_i);
    rst_ni = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 32'h410, 4'h9);
    check("post_rst_head", 64'(result_o), 64'h410);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 4'h0);

    // Pops requested on an empty FIFO must not move anything.
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0, 4'h0);
      check("empty_pop_count", 64'(count_o), 64'd0);
    end
    drive(1'b1, 1'b0, 1'b0, 32'h500, 4'hA);
    drive(1'b1, 1'b0, 1'b0, 32'h501, 4'hB);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 4'h0);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
